// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: operation select codes and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per enabled step.
// acc holds {partial product | remainder, multiplier | quotient}; opnd holds b.
module mc_alu_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           mode_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] next_result
);

  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic [W:0]     mul_sum;
  logic [W:0]     div_diff;

  // next_result is the value acc takes after this step, so the top can capture
  // the final answer in the same cycle as the last iteration.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = acc[2*W-1:W-1] - {1'b0, opnd};
    if (mode_div) begin
      if (div_diff[W])
        next_result = {acc[2*W-2:0], 1'b0};
      else
        next_result = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      next_result = {mul_sum, acc[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{W{1'b0}}, a};
      opnd <= b;
    end else if (step) begin
      acc  <= next_result;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multicycle unsigned ALU with valid/ready on request and result sides.
// Owns the FSM, handshakes, iteration counter, add/sub and the flags.
module mc_alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           c,
  output logic           z
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [1:0]     op_reg;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] iter_next;
  logic [2*W-1:0] y_next;
  logic           c_next;
  logic           exec_last;
  logic           div_zero;
  logic           iter_load;
  logic           iter_step;

  assign in_ready  = (state == IDLE) && !reset;
  assign div_zero  = (b_reg == '0);
  assign iter_load = in_valid && in_ready;
  assign iter_step = (state == EXEC) &&
                     ((op_reg == OP_MUL) || ((op_reg == OP_DIV) && !div_zero));

  mc_alu_iter #(.W(W)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .load       (iter_load),
    .step       (iter_step),
    .mode_div   (op_reg == OP_DIV),
    .a          (a),
    .b          (b),
    .next_result(iter_next)
  );

  // Result selection for the cycle that leaves EXEC; add, sub and divide-by-zero finish at once.
  always_comb begin
    y_next    = '0;
    c_next    = 1'b0;
    exec_last = 1'b1;
    case (op_reg)
      OP_ADD: {c_next, y_next[W-1:0]} = {1'b0, a_reg} + {1'b0, b_reg};
      OP_SUB: begin
        y_next[W-1:0] = a_reg - b_reg;
        c_next        = (a_reg < b_reg);
      end
      OP_MUL: begin
        y_next    = iter_next;
        exec_last = (cnt == '0);
      end
      default: begin
        if (div_zero) begin
          c_next = 1'b1;
        end else begin
          y_next    = iter_next;
          exec_last = (cnt == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_ADD;
      cnt       <= '0;
      y         <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            cnt    <= CW'(W - 1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (iter_step)
            cnt <= cnt - 1'b1;
          if (exec_last) begin
            y         <= y_next;
            c         <= c_next;
            z         <= (y_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu (W=8): directed requests push expectations, a monitor checks results.
module tb_mc_alu;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] y;
    logic           c;
    logic           z;
    int             lat;
    int             acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           c;
  logic           z;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  mc_alu #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .c        (c),
    .z        (z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for in_ready, issues one request, pushes its expectation, then scrambles the inputs.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                               input logic [2*W-1:0] ey, input logic ec, input logic ez, input int el);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL issue_timeout: got in_ready=0 want 1");
    end else begin
      op       = o;
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      e.y = ey; e.c = ec; e.z = ez; e.lat = el; e.acc = cyc;
      sbq.push_back(e);
      @(posedge clk) #1;
      in_valid = 1'b0;
      a  = W'($urandom);
      b  = W'($urandom);
      op = 2'($urandom);
    end
  endtask

  // Monitor: tracks when out_valid rises and checks each consumed result against the queue head.
  initial begin
    exp_t e;
    logic prev_valid;
    int   valid_start;
    prev_valid  = 1'b0;
    valid_start = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid)
          valid_start = cyc;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_result: got y=%0h with empty scoreboard", y);
          end else begin
            e = sbq.pop_front();
            checkOutput("y", 32'(y), 32'(e.y));
            checkOutput("c", 32'(c), 32'(e.c));
            checkOutput("z", 32'(z), 32'(e.z));
            checkOutput("latency", 32'(valid_start - e.acc), 32'(e.lat));
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b1;
    a         = 8'd1;
    b         = 8'd1;
    op        = OP_ADD;
    out_ready = 1'b1;

    // Reset held 3 cycles with a competing request that must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_c", 32'(c), 32'd0);
    checkOutput("rst_z", 32'(z), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk) #1;
    repeat (3) @(posedge clk) #1;

    $display("[TB] add/sub/mul/div directed vectors");
    applyStimulus(OP_ADD, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 2);
    applyStimulus(OP_SUB, 8'd5,   8'd9,   16'h00FC, 1'b1, 1'b0, 2);
    applyStimulus(OP_ADD, 8'd128, 8'd128, 16'h0000, 1'b1, 1'b1, 2);
    applyStimulus(OP_SUB, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 2);
    applyStimulus(OP_MUL, 8'd200, 8'd150, 16'h7530, 1'b0, 1'b0, 9);
    applyStimulus(OP_MUL, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b1, 9);
    applyStimulus(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9);
    applyStimulus(OP_DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9);
    applyStimulus(OP_DIV, 8'd55,  8'd0,   16'h0000, 1'b1, 1'b1, 2);
    applyStimulus(OP_DIV, 8'd255, 8'd255, 16'h0001, 1'b0, 1'b0, 9);
    applyStimulus(OP_DIV, 8'd3,   8'd10,  16'h0300, 1'b0, 1'b0, 9);

    $display("[TB] back-pressure");
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'd10, 8'd20, 16'h001E, 1'b0, 1'b0, 2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 8'd3;
      b        = 8'd4;
      op       = OP_MUL;
      checkOutput("bp_hold_y", 32'(y), 32'h001E);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk) #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    applyStimulus(OP_SUB, 8'd9, 8'd5, 16'h0004, 1'b0, 1'b0, 2);

    $display("[TB] reset during multiply");
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    a        = 8'd200;
    b        = 8'd150;
    op       = OP_MUL;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (12) @(posedge clk) #1;
    applyStimulus(OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 2);

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending results want 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
